float_mul_seq: RTL and testbench
================================

Name: float_mul_seq

Overview:
- Sequential floating-point multiplier for the coprocessor datapath, operating on the team's reduced-format floats (sign, NE-bit biased exponent, NM-bit mantissa).
- Successor to the format-conversion utilities in float_pack. Adds real arithmetic, a selectable rounding mode, saturation and flush-to-zero flags, and a valid/ready handshake.
- Uses an iterative shift-add mantissa multiplier, one partial product per clock, so area stays small for any NE/NM.

Parameters:
- NE, default float_pack::Ne (8): exponent width, range 2..8.
- NM, default float_pack::Nm (23): mantissa width, range 1..23.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  NE+NM+1  operand A, packed {s,e,m}.
- b  in  NE+NM+1  operand B, packed {s,e,m}.
- rnd_mode  in  1  rounding mode: 0 = truncate, 1 = round-to-nearest-even. Sampled at accept.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  NE+NM+1  product, packed {s,e,m}.
- ovf  out  1  result saturated; valid with out_valid.
- unf  out  1  result flushed to zero; valid with out_valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; out_valid=0; y=0; ovf=0; unf=0. in_ready=0 while reset is high, 1 on the first cycle after reset.
- State machine: IDLE, MUL, NORM, DONE.
- in_ready = (state==IDLE). Only one operation is outstanding at a time.
- IDLE: an edge with in_valid&in_ready latches a, b and rnd_mode.
  - Either exponent == 0 (zero): go to DONE with y={sa^sb,0,0}, unf=0. Latency 1.
  - Otherwise: go to MUL with the iteration counter cleared.
- MUL:
  - Multiplicand and multiplier are the mantissas with hidden bit, (1.ma) and (1.mb), each NM+1 bits.
  - Each edge adds the multiplicand to a 2NM+2-bit accumulator when the current multiplier LSB is 1, then shifts.
  - After exactly NM+1 edges, go to NORM.
- NORM (one edge), in order:
  - sign = sa^sb.
  - Exponent: exp = ea + eb - BIAS, computed signed with NE+2 bits, where BIAS = 2^(NE-1)-1.
  - Normalise: if the product MSB is set, shift right 1 and exp+1.
  - Round: keep NM fraction bits. In RNE, use guard, round and sticky bits (sticky = OR of all discarded bits below guard); ties go to the even mantissa.
  - Rounding carry-out: mantissa becomes 0 and exp+1.
  - Overflow, exp > 2^NE-2: y={s, 2^NE-2, all-ones}, ovf=1. This is the same saturation value float_pack uses.
  - Underflow, exp <= 0: y={s,0,0}, unf=1. No denormals.
  - Then go to DONE.
- Latency: for non-zero operands, out_valid rises NM+2 edges after the accept edge (25 for default params).
- DONE: out_valid=1. y, ovf and unf hold stable while out_ready=0. An edge with out_ready=1 sets out_valid=0 and goes to IDLE. in_ready is 0 for the whole DONE state, so there is no same-cycle re-accept.
- Exponent all-ones on an input: treated as an ordinary numeric exponent. There is no Inf/NaN.
- Reset mid-operation: the current operation is abandoned with no output; all registers take their reset values.
- ovf and unf are never both 1.

Decomposition:
- Add to float_pack:
  - localparams BIAS and EMAX_FINITE = 2^Ne-2.
  - typedef enum logic {RND_TRUNC, RND_RNE} rnd_t.
  - Function float_sat(s) returning the saturated value.
- Sub-module float_norm_round: combinational. Inputs: raw product, signed exponent, sign, rnd_mode. Outputs: y, ovf, unf. It is reused later by the adder.

Test Plan:
- 1. Defaults, RNE: a=0x3FC00000 (1.5), b=0x40000000 (2.0) -> y=0x40400000, ovf=0, unf=0, out_valid exactly 25 edges after accept; in_ready=0 throughout.
- 2. Rounding tie: a=0x3F800001, b=0x3FC00000. Truncate -> y=0x3FC00001; RNE -> y=0x3FC00002.
- 3. Overflow: a=b=0x7F000000 -> y=0x7F7FFFFF, ovf=1. Underflow: a=b=0x00800000 -> y=0x00000000, unf=1.
- 4. Zero shortcut: a=0x00000000, b=0xC0000000 -> y=0x80000000, out_valid 1 edge after accept.
- 5. Backpressure and reset: hold out_ready=0 for 5 cycles after out_valid -> y, ovf, unf and out_valid stable, in_ready=0. Assert reset at MUL iteration 10 -> next cycle out_valid=0, y=0; in_ready=1 after reset drops.
- 6. NE=5, NM=10: a=0x3C00 (1.0), b=0x4000 (2.0) -> y=0x4000, latency 12. a=b=0x7800 -> y=0x7BFF, ovf=1.

Source files
------------

// File: rtl/float_pack.sv
// Shared definitions for the reduced-format float datapath: default format,
// rounding-mode and FSM encodings, and the saturation value helper.
package float_pack;

    localparam int Ne = 8;
    localparam int Nm = 23;

    localparam int BIAS        = (1 << (Ne - 1)) - 1;
    localparam int EMAX_FINITE = (1 << Ne) - 2;

    typedef enum logic {RND_TRUNC, RND_RNE} rnd_t;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} mul_state_t;

    // Largest finite magnitude with the requested sign (default format).
    function automatic logic [Ne+Nm:0] float_sat(input logic s);
        logic [Ne-1:0] e_max;
        e_max = EMAX_FINITE[Ne-1:0];
        return {s, e_max, {Nm{1'b1}}};
    endfunction

endpackage

// File: rtl/float_mul_seq_if.sv
// Operand/result handshake bundle for the sequential float multiplier.
interface float_mul_seq_if #(
    parameter int NE = float_pack::Ne,
    parameter int NM = float_pack::Nm
);
    logic          in_valid;
    logic          in_ready;
    logic [NE+NM:0] a;
    logic [NE+NM:0] b;
    logic          rnd_mode;
    logic          out_valid;
    logic          out_ready;
    logic [NE+NM:0] y;
    logic          ovf;
    logic          unf;

    modport master (
        output in_valid, a, b, rnd_mode, out_ready,
        input  in_ready, out_valid, y, ovf, unf
    );

    modport slave (
        input  in_valid, a, b, rnd_mode, out_ready,
        output in_ready, out_valid, y, ovf, unf
    );
endinterface

// File: rtl/float_mul_seq_norm_round.sv
// Combinational normalise / round / range-check stage. Takes a raw 1.x*1.y
// product in [1,4) and its unadjusted signed exponent; also used by the adder.
module float_norm_round
    import float_pack::*;
#(
    parameter int NE = Ne,
    parameter int NM = Nm
) (
    input  logic [2*NM+1:0]        prod,
    input  logic signed [NE+1:0]   exp_in,
    input  logic                   sign,
    input  rnd_t                   rnd_mode,
    output logic [NE+NM:0]         y,
    output logic                   ovf,
    output logic                   unf
);

    // One extra bit over the input exponent absorbs the normalise and carry increments.
    localparam logic signed [NE+2:0] EMAX_S = (NE+3)'((1 << NE) - 2);
    localparam logic [NE-1:0]        EMAX_E = NE'((1 << NE) - 2);

    logic [2*NM:0]          norm;
    logic signed [NE+2:0]   exp_n;
    logic signed [NE+2:0]   exp_r;
    logic [NM-1:0]          frac;
    logic                   guard;
    logic                   rest;
    logic                   inc;
    logic [NM:0]            frac_r;

    // Normalise to a leading one, round the fraction, then clamp the exponent range.
    always_comb begin
        // NOTE: every output and temporary gets a value on every path, so no latch is inferred.
        y   = '0;
        ovf = 1'b0;
        unf = 1'b0;

        // Leading one dropped: a set MSB means the product is in [2,4).
        norm  = prod[2*NM+1] ? prod[2*NM:0] : {prod[2*NM-1:0], 1'b0};
        exp_n = {exp_in[NE+1], exp_in} + {{(NE+2){1'b0}}, prod[2*NM+1]};

        frac  = norm[2*NM:NM+1];
        guard = norm[NM];
        rest  = |norm[NM-1:0];
        // Round up on more than half, or on exactly half when the kept LSB is odd.
        inc   = (rnd_mode == RND_RNE) && guard && (rest || frac[0]);

        frac_r = {1'b0, frac} + (NM+1)'(inc);
        exp_r  = exp_n + {{(NE+2){1'b0}}, frac_r[NM]};

        if (exp_r > EMAX_S) begin
            y   = {sign, EMAX_E, {NM{1'b1}}};
            ovf = 1'b1;
        end else if (exp_r[NE+2] || (exp_r == '0)) begin
            y   = {sign, {(NE+NM){1'b0}}};
            unf = 1'b1;
        end else begin
            // A carry out of the fraction leaves frac_r[NM-1:0] all zero.
            y   = {sign, exp_r[NE-1:0], frac_r[NM-1:0]};
        end
    end

endmodule

// File: rtl/float_mul_seq.sv
// Sequential reduced-format float multiplier: one shift-add partial product
// per clock, followed by a single normalise/round cycle. The first partial
// product is formed on the accept edge straight from the operand inputs.
module float_mul_seq
    import float_pack::*;
#(
    parameter int NE = Ne,
    parameter int NM = Nm
) (
    input  logic           clk,
    input  logic           reset,
    float_mul_seq_if.slave bus
);

    localparam int W  = NE + NM + 1;
    localparam int CW = $clog2(NM + 1) + 1;
    localparam logic [NE+1:0] BIAS_N = (NE+2)'((1 << (NE - 1)) - 1);
    localparam logic [CW-1:0] LAST   = CW'(NM - 1);

    mul_state_t state, state_nxt;

    logic                  sign_q;
    logic [NE-1:0]         ea_q;
    logic [NE-1:0]         eb_q;
    logic [NM:0]           mcand_q;
    logic [2*NM+1:0]       acc_q;
    logic [CW-1:0]         cnt_q;
    rnd_t                  rnd_q;
    logic [W-1:0]          y_q;
    logic                  ovf_q;
    logic                  unf_q;

    logic                  accept;
    logic                  any_zero;
    logic [2*NM+1:0]       acc_src;
    logic [NM:0]           mcand_src;
    logic [NM+1:0]         partial;
    logic [2*NM+1:0]       acc_step;
    logic signed [NE+1:0]  exp_raw;
    logic [W-1:0]          nr_y;
    logic                  nr_ovf;
    logic                  nr_unf;

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = (state == DONE);
    assign bus.y         = y_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

    assign accept   = bus.in_valid && bus.in_ready;
    assign any_zero = (bus.a[W-2:NM] == '0) || (bus.b[W-2:NM] == '0);

    // One shift-add step; the multiplier sits in the low half of the accumulator
    // and is consumed LSB-first as the product shifts in from the top.
    always_comb begin
        acc_src   = (state == IDLE) ? {{(NM+1){1'b0}}, 1'b1, bus.b[NM-1:0]} : acc_q;
        mcand_src = (state == IDLE) ? {1'b1, bus.a[NM-1:0]} : mcand_q;
        partial   = {1'b0, acc_src[2*NM+1:NM+1]} + (acc_src[0] ? {1'b0, mcand_src} : '0);
        acc_step  = {partial, acc_src[NM:1]};
    end

    assign exp_raw = {2'b00, ea_q} + {2'b00, eb_q} - BIAS_N;

    float_norm_round #(.NE(NE), .NM(NM)) u_norm_round (
        .prod     (acc_q),
        .exp_in   (exp_raw),
        .sign     (sign_q),
        .rnd_mode (rnd_q),
        .y        (nr_y),
        .ovf      (nr_ovf),
        .unf      (nr_unf)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode: zero operands skip straight to DONE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = any_zero ? DONE : MUL;
            MUL:  if (cnt_q == LAST) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: datapath registers are reset as well, so an abandoned operation leaves nothing behind.
            sign_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            rnd_q   <= RND_TRUNC;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q  <= bus.a[W-1] ^ bus.b[W-1];
                        ea_q    <= bus.a[W-2:NM];
                        eb_q    <= bus.b[W-2:NM];
                        mcand_q <= {1'b1, bus.a[NM-1:0]};
                        acc_q   <= acc_step;
                        cnt_q   <= '0;
                        rnd_q   <= rnd_t'(bus.rnd_mode);
                        if (any_zero) begin
                            y_q   <= {bus.a[W-1] ^ bus.b[W-1], {(W-1){1'b0}}};
                            ovf_q <= 1'b0;
                            unf_q <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                NORM: begin
                    y_q   <= nr_y;
                    ovf_q <= nr_ovf;
                    unf_q <= nr_unf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_mul_seq.sv
// Directed bench for float_mul_seq: default format plus an NE=5/NM=10 instance.
module tb_float_mul_seq;

    logic clk = 1'b0;
    logic reset;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    float_mul_seq_if                  bus0 ();
    float_mul_seq_if #(.NE(5), .NM(10)) bus1 ();

    float_mul_seq u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    float_mul_seq #(.NE(5), .NM(10)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation on the default instance; lat counts edges from the
    // accept edge (inclusive) until out_valid is seen, bounded at 200.
    task automatic op0(input logic [31:0] a, input logic [31:0] b, input logic rnd,
                       output int lat, output logic rdy_low);
        bus0.a        = a;
        bus0.b        = b;
        bus0.rnd_mode = rnd;
        bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        lat     = 1;
        rdy_low = 1'b1;
        while (!bus0.out_valid && lat < 200) begin
            if (bus0.in_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (bus0.in_ready) rdy_low = 1'b0;
    endtask

    task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic rnd,
                       output int lat);
        bus1.a        = a;
        bus1.b        = b;
        bus1.rnd_mode = rnd;
        bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        lat = 1;
        while (!bus1.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release0();
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
    endtask

    task automatic release1();
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        logic rdy_low;
        logic seen;

        reset          = 1'b1;
        bus0.in_valid  = 1'b0;
        bus0.a         = '0;
        bus0.b         = '0;
        bus0.rnd_mode  = 1'b0;
        bus0.out_ready = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.a         = '0;
        bus1.b         = '0;
        bus1.rnd_mode  = 1'b0;
        bus1.out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  bus0.in_ready, 0);
        check("rst_out_valid", bus0.out_valid, 0);
        check("rst_y",         bus0.y, 0);
        check("rst_ovf",       bus0.ovf, 0);
        check("rst_unf",       bus0.unf, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", bus0.in_ready, 1);

        // 1.5 * 2.0, RNE.
        op0(32'h3FC0_0000, 32'h4000_0000, 1'b1, lat, rdy_low);
        check("t1_latency", lat, 25);
        check("t1_ready_low", rdy_low, 1);
        check("t1_y",   bus0.y, 32'h4040_0000);
        check("t1_ovf", bus0.ovf, 0);
        check("t1_unf", bus0.unf, 0);

        // Backpressure: result holds while out_ready is low.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", bus0.out_valid, 1);
            check("bp_y",         bus0.y, 32'h4040_0000);
            check("bp_flags",     {bus0.ovf, bus0.unf}, 2'b00);
            check("bp_in_ready",  bus0.in_ready, 0);
        end
        release0();
        check("bp_drop_valid", bus0.out_valid, 0);
        check("bp_back_ready", bus0.in_ready, 1);

        // Rounding tie: truncate vs RNE.
        op0(32'h3F80_0001, 32'h3FC0_0000, 1'b0, lat, rdy_low);
        check("tie_trunc_y", bus0.y, 32'h3FC0_0001);
        release0();
        op0(32'h3F80_0001, 32'h3FC0_0000, 1'b1, lat, rdy_low);
        check("tie_rne_y", bus0.y, 32'h3FC0_0002);
        release0();

        // Overflow saturation and underflow flush.
        op0(32'h7F00_0000, 32'h7F00_0000, 1'b1, lat, rdy_low);
        check("ovf_y",     bus0.y, 32'h7F7F_FFFF);
        check("ovf_flags", {bus0.ovf, bus0.unf}, 2'b10);
        release0();
        op0(32'h0080_0000, 32'h0080_0000, 1'b1, lat, rdy_low);
        check("unf_y",     bus0.y, 32'h0000_0000);
        check("unf_flags", {bus0.ovf, bus0.unf}, 2'b01);
        release0();

        // Zero shortcut keeps the product sign.
        op0(32'h0000_0000, 32'hC000_0000, 1'b1, lat, rdy_low);
        check("zero_latency", lat, 1);
        check("zero_y",       bus0.y, 32'h8000_0000);
        check("zero_flags",   {bus0.ovf, bus0.unf}, 2'b00);
        release0();

        // Negative operand and a product needing normalisation.
        op0(32'hC000_0000, 32'h4040_0000, 1'b0, lat, rdy_low);
        check("neg_y", bus0.y, 32'hC0C0_0000);
        release0();
        op0(32'h3FC0_0000, 32'h3FC0_0000, 1'b1, lat, rdy_low);
        check("norm_y", bus0.y, 32'h4010_0000);
        release0();

        // Reset in the middle of MUL abandons the operation.
        bus0.a        = 32'h3FC0_0000;
        bus0.b        = 32'h4000_0000;
        bus0.rnd_mode = 1'b1;
        bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", bus0.out_valid, 0);
        check("mid_rst_y",         bus0.y, 0);
        check("mid_rst_in_ready",  bus0.in_ready, 0);
        reset = 1'b0;
        #1;
        check("mid_rst_ready_after", bus0.in_ready, 1);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus0.out_valid) seen = 1'b1;
        end
        check("mid_rst_no_output", seen, 0);
        op0(32'h3FC0_0000, 32'h4000_0000, 1'b1, lat, rdy_low);
        check("recover_latency", lat, 25);
        check("recover_y",       bus0.y, 32'h4040_0000);
        release0();

        // Small format: NE=5, NM=10.
        op1(16'h3C00, 16'h4000, 1'b1, lat);
        check("small_latency", lat, 12);
        check("small_y",       bus1.y, 16'h4000);
        check("small_flags",   {bus1.ovf, bus1.unf}, 2'b00);
        release1();
        op1(16'h7800, 16'h7800, 1'b1, lat);
        check("small_ovf_y",     bus1.y, 16'h7BFF);
        check("small_ovf_flags", {bus1.ovf, bus1.unf}, 2'b10);
        release1();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
